// File: rtl/flappy_pkg.sv
// Shared definitions for the Flappy Bird datapath: field geometry, the pipe
// generator state encoding and the 8-bit LFSR step used by random sources.
package flappy_pkg;

   localparam int ROWS = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } pipe_gen_state_t;

   // Fibonacci step, taps 8,6,5,4; a nonzero value never reaches zero.
   function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR that steps only when adv is high; q shows the value
// before the step so a consumer sees the current draw in the advancing cycle.
module lfsr8
   import flappy_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       adv,
   output logic [7:0] q
);

   logic [7:0] q_q;

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= SEED;
      end else if (adv) begin
         q_q <= lfsr8_next(q_q);
      end
   end

   assign q = q_q;

endmodule

// File: rtl/pipe_gen.sv
// Pipe-field feeder: paces a one-cycle shift strobe from the system clock and
// supplies the column loaded on each strobe, with a pseudo-random pipe gap.
module pipe_gen
   import flappy_pkg::*;
#(
   parameter int         SCROLL_DIV = 12_500_000,
   parameter int         SPACING    = 4,
   parameter int         GAP_H      = 4,
   parameter logic [7:0] SEED       = 8'hA5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            gameover,
   output logic            clkP,
   output logic [ROWS-1:0] newPipe
);

   localparam int TW = $clog2(SCROLL_DIV);
   localparam int CW = (SPACING > 1) ? $clog2(SPACING) : 1;
   localparam logic [ROWS-1:0] GAP_MASK = ROWS'((1 << GAP_H) - 1);

   pipe_gen_state_t state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [CW-1:0]   col_q, col_d;
   logic            clkp_q, clkp_d;
   logic [ROWS-1:0] newpipe_q, newpipe_d;
   logic            adv;
   logic [7:0]      lfsr_q;
   logic [3:0]      gap;
   logic [ROWS-1:0] pipe_col;
   logic            lfsr_unused;

   lfsr8 #(.SEED(SEED)) u_lfsr (
      .clk  (clk),
      .reset(reset),
      .adv  (adv),
      .q    (lfsr_q)
   );

   // Only the low nibble places the gap; the upper bits just extend the period.
   assign lfsr_unused = ^lfsr_q[7:4];

   always_comb begin
      gap = lfsr_q[3:0];
      if (gap > 4'(ROWS - GAP_H)) begin
         gap = gap - 4'(ROWS + 1 - GAP_H);
      end
      pipe_col = ~(GAP_MASK << gap);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         col_q     <= '0;
         clkp_q    <= 1'b0;
         newpipe_q <= '0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         col_q     <= col_d;
         clkp_q    <= clkp_d;
         newpipe_q <= newpipe_d;
      end
   end

   // NOTE: every output of this block gets a default first so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      col_d     = col_q;
      clkp_d    = 1'b0;
      newpipe_d = newpipe_q;
      adv       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && !gameover) begin
               state_d = RUN;
               tick_d  = '0;
            end
         end
         RUN: begin
            // gameover wins over a pending wrap so the field freezes on that edge
            if (gameover) begin
               state_d = HALT;
            end else if (tick_q == TW'(SCROLL_DIV - 1)) begin
               tick_d = '0;
               clkp_d = 1'b1;
               adv    = 1'b1;
               col_d  = (col_q == CW'(SPACING - 1)) ? '0 : col_q + CW'(1);
               newpipe_d = (col_q == CW'(SPACING - 1)) ? pipe_col : '0;
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign clkP    = clkp_q;
   assign newPipe = newpipe_q;

endmodule

// File: tb/tb_pipe_gen.sv
// Self-checking bench for pipe_gen: directed table of strobe columns, corner
// sequences, and random start/gameover traffic against a behavioural model.
module tb_pipe_gen;

   localparam int         DIV    = 4;
   localparam int         SPC    = 3;
   localparam int         GH     = 4;
   localparam logic [7:0] SEED_A = 8'hA5;
   // Two steps from 8'h83 reach 8'h0E, so strobe 3 draws a low nibble of 14.
   localparam logic [7:0] SEED_B = 8'h83;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_r = 1'b0;
   logic        gameover_r = 1'b0;
   logic        clkp_a, clkp_b;
   logic [15:0] np_a, np_b;

   int checks = 0;
   int errors = 0;

   // model: 0 idle, 1 run, 2 halt; m_cnt = edges since RUN entry
   int          m_st;
   int          m_cnt;
   logic        m_clkp;
   logic [15:0] m_np_a, m_np_b;

   typedef struct {
      int          k;
      logic [15:0] exp_a;
      logic [15:0] exp_b;
   } vec_t;
   vec_t vecs[4];

   always #5 clk = ~clk;

   pipe_gen #(.SCROLL_DIV(DIV), .SPACING(SPC), .GAP_H(GH), .SEED(SEED_A)) dut_a (
      .clk     (clk),
      .reset   (rst),
      .start   (start_r),
      .gameover(gameover_r),
      .clkP    (clkp_a),
      .newPipe (np_a)
   );

   pipe_gen #(.SCROLL_DIV(DIV), .SPACING(SPC), .GAP_H(GH), .SEED(SEED_B)) dut_b (
      .clk     (clk),
      .reset   (rst),
      .start   (start_r),
      .gameover(gameover_r),
      .clkP    (clkp_b),
      .newPipe (np_b)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Column for the k-th strobe, derived straight from the gap rules.
   function automatic logic [15:0] exp_col(input int k, input logic [7:0] seed);
      logic [7:0] v;
      int         g;
      logic [15:0] mask;
      v = seed;
      for (int i = 1; i < k; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      if (k % SPC != 0) return 16'h0000;
      g = int'(v[3:0]);
      if (g > 16 - GH) g = g - (17 - GH);
      mask = 16'((1 << GH) - 1);
      return 16'hFFFF ^ (mask << g);
   endfunction

   function automatic void model_reset();
      m_st   = 0;
      m_cnt  = 0;
      m_clkp = 1'b0;
      m_np_a = 16'h0000;
      m_np_b = 16'h0000;
   endfunction

   function automatic void model_step();
      m_clkp = 1'b0;
      case (m_st)
         0: if (start_r && !gameover_r) begin
               m_st  = 1;
               m_cnt = 0;
            end
         1: if (gameover_r) begin
               m_st = 2;
            end else begin
               m_cnt++;
               if (m_cnt % DIV == 0) begin
                  m_clkp = 1'b1;
                  m_np_a = exp_col(m_cnt / DIV, SEED_A);
                  m_np_b = exp_col(m_cnt / DIV, SEED_B);
               end
            end
         default: ;
      endcase
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("clkP_a", 16'(clkp_a), 16'(m_clkp));
      check("clkP_b", 16'(clkp_b), 16'(m_clkp));
      check("newPipe_a", np_a, m_np_a);
      check("newPipe_b", np_b, m_np_b);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Called just after a sample point: reset lands mid-cycle, between edges.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_clkP", 16'(clkp_a), 16'h0000);
      check("rst_newPipe_a", np_a, 16'h0000);
      check("rst_newPipe_b", np_b, 16'h0000);
      model_reset();
      start_r    = 1'b0;
      gameover_r = 1'b0;
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic pulse_start();
      start_r = 1'b1;
      cycle();
      start_r = 1'b0;
   endtask

   task automatic wait_strobe(input string name);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!clkp_a && n < 4 * DIV);
      check({name, "_seen"}, 16'(clkp_a), 16'h0001);
   endtask

   initial begin
      vecs[0] = '{k: 1, exp_a: 16'h0000, exp_b: 16'h0000};
      vecs[1] = '{k: 2, exp_a: 16'h0000, exp_b: 16'h0000};
      vecs[2] = '{k: 3, exp_a: 16'hFE1F, exp_b: 16'hFFE1};
      vecs[3] = '{k: 4, exp_a: 16'h0000, exp_b: 16'h0000};

      model_reset();
      #3;
      check("init_clkP", 16'(clkp_a), 16'h0000);
      check("init_newPipe", np_a, 16'h0000);
      @(negedge clk) rst = 1'b0;

      // idle with start low
      cycles(20);

      // first strobe exactly DIV edges after the RUN entry edge
      pulse_start();
      cycles(DIV - 1);
      check("no_early_strobe", 16'(clkp_a), 16'h0000);

      for (int i = 0; i < 4; i++) begin
         wait_strobe($sformatf("strobe%0d", vecs[i].k));
         check($sformatf("vec%0d_a", vecs[i].k), np_a, vecs[i].exp_a);
         check($sformatf("vec%0d_b", vecs[i].k), np_b, vecs[i].exp_b);
         if (i < 3) begin
            cycle();
            check("strobe_one_cycle", 16'(clkp_a), 16'h0000);
         end
      end

      // gameover on the edge that would have issued strobe 5
      while (m_cnt < 5 * DIV - 1 && m_st == 1) cycle();
      gameover_r = 1'b1;
      cycle();
      check("gameover_no_strobe", 16'(clkp_a), 16'h0000);
      gameover_r = 1'b0;
      start_r    = 1'b1;
      cycles(50);
      start_r = 1'b0;

      // reset in the middle of RUN, right after the FE1F column appears
      do_reset();
      pulse_start();
      for (int i = 0; i < 3; i++) wait_strobe("rerun");
      check("rerun_strobe3_a", np_a, 16'hFE1F);
      do_reset();
      pulse_start();
      for (int i = 0; i < 3; i++) wait_strobe("rerun2");
      check("rerun2_strobe3_a", np_a, 16'hFE1F);
      check("rerun2_strobe3_b", np_b, 16'hFFE1);

      // start and gameover together in IDLE keep it idle
      do_reset();
      start_r    = 1'b1;
      gameover_r = 1'b1;
      cycles(2 * DIV);
      start_r    = 1'b0;
      gameover_r = 1'b0;
      cycles(DIV + 1);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if (i % 600 == 599) do_reset();
         start_r    = ($urandom_range(0, 9) == 0);
         gameover_r = ($urandom_range(0, 249) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
